// File: rtl/reshaper_pkg.sv
// reshaper_pkg: constants and types shared by the stream reshaper blocks
package reshaper_pkg;
  localparam int SKID_DEPTH = 2;
  typedef logic [$clog2(SKID_DEPTH+1)-1:0] skid_cnt_t;
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: FIFO read port plus output stream; burst_len/m_last exist only with FIFO_RD_LAST_EN
interface fifo_rd_ctrl_if #(parameter int DW = 8, parameter int BLW = 16);
  logic          en;
  logic          ffrempty;
  logic          ffrreq;
  logic [DW-1:0] ffrdata;
  logic          ffrvld;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_LAST_EN
  logic [BLW-1:0] burst_len;
  logic           m_last;
  modport master (input en, ffrempty, ffrdata, ffrvld, m_ready, burst_len,
                  output ffrreq, m_valid, m_data, m_last);
  modport slave  (output en, ffrempty, ffrdata, ffrvld, m_ready, burst_len,
                  input ffrreq, m_valid, m_data, m_last);
`else
  modport master (input en, ffrempty, ffrdata, ffrvld, m_ready,
                  output ffrreq, m_valid, m_data);
  modport slave  (output en, ffrempty, ffrdata, ffrvld, m_ready,
                  input ffrreq, m_valid, m_data);
`endif
endinterface

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: 2-entry in-order buffer with registered head, simultaneous push/pop
module rd_skid_buf
  import reshaper_pkg::*;
#(parameter int DW = 8) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output skid_cnt_t     cnt
);
  logic [DW-1:0] b0_q, b0_d, b1_q, b1_d;
  skid_cnt_t cnt_q, cnt_d;
  logic tail1;
  // tail slot is computed after the pop shifts entry 1 down to the head
  always_comb begin
    tail1 = (cnt_q - skid_cnt_t'(pop)) == skid_cnt_t'(1);
    cnt_d = cnt_q + skid_cnt_t'(push) - skid_cnt_t'(pop);
    b0_d  = (push && !tail1) ? din : pop ? b1_q : b0_q;
    b1_d  = (push && tail1) ? din : b1_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      b0_q  <= '0;
      b1_q  <= '0;
      cnt_q <= '0;
    end else begin
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = b0_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read controller feeding a valid/ready stream via a 2-entry skid buffer
// Optional burst marking (beat counter, burst_len, m_last) with macro FIFO_RD_LAST_EN.
module fifo_rd_ctrl
  import reshaper_pkg::*;
#(parameter int DW = 8, parameter int BLW = 16) (
  input logic           clk,
  input logic           reset_n,
  fifo_rd_ctrl_if.master bus
);
  skid_cnt_t cnt;
  logic [DW-1:0] head;
  logic infl_q, infl_d, pop, req;
  rd_skid_buf #(.DW(DW)) u_buf (
    .clk, .reset_n, .push(bus.ffrvld), .pop, .din(bus.ffrdata), .dout(head), .cnt
  );
  // count the in-flight word so a full buffer is never overrun
  always_comb begin
    pop    = (cnt != '0) && bus.m_ready;
    req    = reset_n && bus.en && !bus.ffrempty &&
             (int'(cnt) + int'(infl_q) - int'(pop)) < SKID_DEPTH;
    infl_d = req;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) infl_q <= 1'b0;
    else          infl_q <= infl_d;
  end
  assign bus.ffrreq  = req;
  assign bus.m_valid = cnt != '0;
  assign bus.m_data  = head;
`ifdef FIFO_RD_LAST_EN
  logic [BLW-1:0] beat_q, beat_d, last_idx;
  logic last;
  always_comb begin
    last_idx = (bus.burst_len == '0) ? '0 : bus.burst_len - BLW'(1);
    last     = beat_q == last_idx;
    beat_d   = pop ? (last ? '0 : beat_q + BLW'(1)) : beat_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) beat_q <= '0;
    else          beat_q <= beat_d;
  end
  assign bus.m_last = (cnt != '0) && last;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl with a behavioural FIFO on the read side
module tb_fifo_rd_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] mem [0:127];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int underflow = 0;
  int base;
  int got;
  fifo_rd_ctrl_if #(.DW(8), .BLW(16)) bus ();
  fifo_rd_ctrl #(.DW(8), .BLW(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));
  always #5 clk = ~clk;
  assign bus.ffrempty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (bus.ffrreq && bus.ffrempty) underflow <= underflow + 1;
    bus.ffrvld <= bus.ffrreq && !bus.ffrempty;
    if (bus.ffrreq && !bus.ffrempty) begin
      bus.ffrdata <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) mem[wr_ptr + i] = first + 8'(i);
    wr_ptr = wr_ptr + n;
  endtask
  initial begin
    reset_n = 1'b0;
    bus.en = 1'b0;
    bus.m_ready = 1'b0;
    bus.ffrvld = 1'b0;
    bus.ffrdata = '0;
`ifdef FIFO_RD_LAST_EN
    bus.burst_len = 16'd3;
`endif
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    // preload 8 words while still in reset: no request may leave
    load(8, 8'h01);
    bus.en = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    chk("rst_ffrreq", 32'(bus.ffrreq), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("lat_not_yet", 32'(bus.m_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("stream8", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, 8'(k)});
    end
    @(negedge clk);
    chk("stream8_idle", 32'(bus.m_valid), 32'd0);
    chk("no_underflow1", 32'(underflow), 32'd0);
    // backpressure: only two words may be pulled
    bus.m_ready = 1'b0;
    base = rd_ptr;
    load(4, 8'h01);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 2) chk("bp_hold", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, 8'h01});
    end
    chk("bp_reads", 32'(rd_ptr - base), 32'd2);
    bus.m_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("bp_release", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, 8'(k)});
    end
    @(negedge clk);
    chk("bp_idle", 32'(bus.m_valid), 32'd0);
    // m_ready toggling every cycle over 16 words
    bus.m_ready = 1'b0;
    load(16, 8'h41);
    got = 0;
    for (int c = 0; c < 80 && got < 16; c++) begin
      @(negedge clk);
      bus.m_ready = ~bus.m_ready;
      if (bus.m_valid && bus.m_ready) begin
        chk("tog_data", 32'(bus.m_data), 32'(8'h41 + 8'(got)));
        got++;
      end
    end
    chk("tog_count", 32'(got), 32'd16);
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("tog_drained", 32'(bus.m_valid), 32'd0);
    chk("tog_fifo_empty", 32'(wr_ptr - rd_ptr), 32'd0);
    // reset mid-stream with a full skid buffer
    bus.m_ready = 1'b0;
    base = rd_ptr;
    load(4, 8'h61);
    repeat (4) @(negedge clk);
    chk("pre_rst_reads", 32'(rd_ptr - base), 32'd2);
    chk("pre_rst_head", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, 8'h61});
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst_data", 32'(bus.m_data), 32'd0);
    reset_n = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("resume_lat", 32'(bus.m_valid), 32'd0);
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      chk("resume", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, 8'h60 + 8'(k)});
    end
    @(negedge clk);
    chk("resume_idle", 32'(bus.m_valid), 32'd0);
    chk("no_underflow2", 32'(underflow), 32'd0);
`ifdef FIFO_RD_LAST_EN
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.burst_len = 16'd3;
    load(9, 8'h81);
    got = 0;
    for (int c = 0; c < 40 && got < 9; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        got++;
        chk("last_bl3", 32'(bus.m_last), 32'(got % 3 == 0));
      end
    end
    chk("bl3_beats", 32'(got), 32'd9);
    bus.burst_len = 16'd0;
    load(3, 8'h91);
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        got++;
        chk("last_bl0", 32'(bus.m_last), 32'd1);
      end
    end
    chk("bl0_beats", 32'(got), 32'd3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
